// File: rtl/dll_pkg.sv
// Shared types for the doubly-linked-list controller and its client front end.
// Holds the list geometry (number of queues, number of payload slots), the
// command opcode, and the client-side FSM state and response record.
package dll_pkg;

  localparam int ID_N     = 4;
  localparam int PTR_N    = 8;
  localparam int ID_W     = $clog2(ID_N);
  localparam int PTR_W    = $clog2(PTR_N);
  localparam int CLIENT_W = 32;

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [ID_N-1:0]  empty_t;

  typedef enum logic [1:0] {
    PUSH_FRONT = 2'd0,
    PUSH_BACK  = 2'd1,
    POP_FRONT  = 2'd2,
    POP_BACK   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } client_state_t;

  typedef struct packed {
    logic                vld;
    logic                err;
    logic [CLIENT_W-1:0] dat;
  } client_rsp_t;

  function automatic logic op_is_pop(input op_t op);
    return (op == POP_FRONT) || (op == POP_BACK);
  endfunction

endpackage

// File: rtl/spsram.sv
// Single-port synchronous RAM used as the payload store.
// Ports: clk; en gates any access; wen=1 writes din at addr, wen=0 reads
// addr into dout on the next edge (dout holds otherwise).
module spsram #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 wen,
  input  logic [$clog2(N)-1:0] addr,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) mem[addr] <= din;
      else     dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/doubly_linked_list_client.sv
// Request-side front end of the doubly-linked-list controller.
// Arbitrates push/pop requests, issues one command at a time on cmd_*,
// keeps payloads in a local RAM addressed by the controller's pointers and
// returns pop data (or an empty-queue error) on the rsp_* channel.
// Ports:
//   push_vld/push_id/push_back/push_dat/push_rdy : push request channel
//   pop_vld/pop_id/pop_back/pop_rdy              : pop request channel
//   rsp_vld/rsp_dat/rsp_err/rsp_rdy              : pop response channel
//   clear_req -> clear                           : flush request / pulse
//   cmd_pass/cmd_op/cmd_id                       : command to controller
//   cmd_push_ptr_r/cmd_pop_ptr_w/full_r/busy_r/nempty_r : controller status
module doubly_linked_list_client
  import dll_pkg::*;
#(
  parameter int W = CLIENT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  id_t          push_id,
  input  logic         push_back,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  input  logic         pop_vld,
  input  id_t          pop_id,
  input  logic         pop_back,
  output logic         pop_rdy,
  output logic         rsp_vld,
  output logic [W-1:0] rsp_dat,
  output logic         rsp_err,
  input  logic         rsp_rdy,
  input  logic         clear_req,
  output logic         cmd_pass,
  output op_t          cmd_op,
  output id_t          cmd_id,
  input  ptr_t         cmd_push_ptr_r,
  input  ptr_t         cmd_pop_ptr_w,
  input  logic         full_r,
  input  logic         busy_r,
  input  empty_t       nempty_r,
  output logic         clear
);

  client_state_t state, state_nx;
  client_rsp_t   rsp_q;
  logic          rr;          // 0 favours push, 1 favours pop
  logic [W-1:0]  pay_p1;
  logic [W-1:0]  ram_dout;
  logic          idle, rsp_stall, push_el, pop_el;
  logic          push_acc, pop_acc, pop_hit, pop_miss;
  logic          cmd_is_pop;

  assign idle      = (state == IDLE) & !rst;
  assign rsp_stall = rsp_q.vld & !rsp_rdy;
  assign push_el   = push_vld & !full_r;
  assign pop_el    = pop_vld & !rsp_stall;

  // The round-robin bit only matters when both sides are eligible.
  assign push_rdy = idle & !clear_req & push_el & (!pop_el | !rr);
  assign pop_rdy  = idle & !clear_req & pop_el & (!push_el | rr);

  assign push_acc   = push_vld & push_rdy;
  assign pop_acc    = pop_vld & pop_rdy;
  assign pop_hit    = pop_acc & nempty_r[pop_id];
  assign pop_miss   = pop_acc & !nempty_r[pop_id];
  assign cmd_is_pop = op_is_pop(cmd_op);

  assign rsp_vld = rsp_q.vld;
  assign rsp_err = rsp_q.err;
  assign rsp_dat = rsp_q.dat;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (push_acc | pop_hit) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr       <= 1'b0;
      cmd_pass <= 1'b0;
      cmd_op   <= PUSH_FRONT;
      cmd_id   <= '0;
      clear    <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state    <= state_nx;
      cmd_pass <= push_acc | pop_hit;
      clear    <= idle & clear_req;
      if (push_acc | pop_acc) rr <= ~rr;
      // accept stage: latch the command for the ISSUE cycle
      if (push_acc) begin
        cmd_op <= push_back ? PUSH_BACK : PUSH_FRONT;
        cmd_id <= push_id;
      end else if (pop_hit) begin
        cmd_op <= pop_back ? POP_BACK : POP_FRONT;
        cmd_id <= pop_id;
      end
      // response stage: a load always wins over the consume of the old entry
      if ((state == WAIT) && cmd_is_pop)
        rsp_q <= '{vld: 1'b1, err: 1'b0, dat: ram_dout};
      else if (pop_miss)
        rsp_q <= '{vld: 1'b1, err: 1'b1, dat: '0};
      else if (rsp_q.vld & rsp_rdy)
        rsp_q.vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) pay_p1 <= push_dat;
  end

  // issue stage: RAM access with the pointer the controller offers this cycle
  spsram #(.W(W), .N(PTR_N)) u_ram (
    .clk  (clk),
    .en   (state == ISSUE),
    .wen  (!cmd_is_pop),
    .addr (cmd_is_pop ? cmd_pop_ptr_w : cmd_push_ptr_r),
    .din  (pay_p1),
    .dout (ram_dout)
  );

  // The controller is busy while the command it just took is in flight.
  wait_busy_a: assert property (@(posedge clk) disable iff (rst)
                                (state == WAIT) |-> busy_r);

endmodule

// File: tb/tb_doubly_linked_list_client.sv
module tb_doubly_linked_list_client;
  import dll_pkg::*;
  localparam int W = 32;

  logic clk, rst;
  logic push_vld, push_back, pop_vld, pop_back, rsp_rdy, clear_req;
  id_t push_id, pop_id, cmd_id;
  logic [W-1:0] push_dat, rsp_dat;
  logic push_rdy, pop_rdy, rsp_vld, rsp_err, cmd_pass, clear;
  op_t cmd_op;
  ptr_t cmd_push_ptr_r, cmd_pop_ptr_w;
  logic full_r, busy_r;
  empty_t nempty_r;

  doubly_linked_list_client #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .push_vld(push_vld), .push_id(push_id), .push_back(push_back),
    .push_dat(push_dat), .push_rdy(push_rdy),
    .pop_vld(pop_vld), .pop_id(pop_id), .pop_back(pop_back), .pop_rdy(pop_rdy),
    .rsp_vld(rsp_vld), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .rsp_rdy(rsp_rdy),
    .clear_req(clear_req), .cmd_pass(cmd_pass), .cmd_op(cmd_op), .cmd_id(cmd_id),
    .cmd_push_ptr_r(cmd_push_ptr_r), .cmd_pop_ptr_w(cmd_pop_ptr_w),
    .full_r(full_r), .busy_r(busy_r), .nempty_r(nempty_r), .clear(clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: per-queue data deques plus request/response timing.
  logic [W-1:0] dq [ID_N][$];
  int           m_busy;        // cycles left before IDLE; 2 = cmd_pass cycle
  logic         m_rr;
  logic         m_rsp_vld, m_rsp_err;
  logic [W-1:0] m_rsp_dat, m_pend_dat;
  int           m_rsp_cnt;
  logic         m_clear_exp;
  op_t          m_cmd_op;
  id_t          m_cmd_id;
  logic         last_pa, last_oa;

  // Controller stand-in: pointer deques per queue plus a free list.
  int unsigned pq [ID_N][$];
  int unsigned fl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  task automatic drive_ctrl(input logic wait_cycle);
    full_r = (fl.size() == 0);
    cmd_push_ptr_r = full_r ? '0 : ptr_t'(fl[0]);
    for (int i = 0; i < ID_N; i++) nempty_r[i] = (pq[i].size() != 0);
    busy_r = wait_cycle;
    cmd_pop_ptr_w = '0;
    if (cmd_op == POP_FRONT && pq[cmd_id].size() > 0) cmd_pop_ptr_w = ptr_t'(pq[cmd_id][0]);
    if (cmd_op == POP_BACK  && pq[cmd_id].size() > 0) cmd_pop_ptr_w = ptr_t'(pq[cmd_id][$]);
  endtask

  task automatic ctrl_clear();
    for (int i = 0; i < ID_N; i++) pq[i].delete();
    fl.delete();
    for (int p = 0; p < PTR_N; p++) fl.push_back(p);
  endtask

  task automatic model_reset();
    ctrl_clear();
    for (int i = 0; i < ID_N; i++) dq[i].delete();
    m_busy = 0; m_rr = 1'b0; m_rsp_vld = 1'b0; m_rsp_err = 1'b0;
    m_rsp_dat = '0; m_pend_dat = '0; m_rsp_cnt = 0; m_clear_exp = 1'b0;
    m_cmd_op = PUSH_FRONT; m_cmd_id = '0; last_pa = 1'b0; last_oa = 1'b0;
    drive_ctrl(1'b0);
  endtask

  task automatic inputs_zero();
    push_vld = 0; push_id = '0; push_back = 0; push_dat = '0;
    pop_vld = 0; pop_id = '0; pop_back = 0; rsp_rdy = 0; clear_req = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_push_rdy", 32'(push_rdy), 0);
    chk("rst_pop_rdy", 32'(pop_rdy), 0);
    chk("rst_cmd_pass", 32'(cmd_pass), 0);
    chk("rst_clear", 32'(clear), 0);
    chk("rst_rsp_vld", 32'(rsp_vld), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_cmd_op", 32'(cmd_op), 0);
    chk("rst_cmd_id", 32'(cmd_id), 0);
    chk("rst_rsp_dat", rsp_dat, 0);
  endtask

  // One clock: compare at negedge, then advance model and stand-in after the edge.
  task automatic step();
    logic idle, pel, oel, exp_prdy, exp_ordy, pa, oa, take, fire, clr, clr_next;
    op_t fop;
    id_t fid;
    int unsigned p;
    @(negedge clk);
    idle = (m_busy == 0);
    pel  = push_vld & ~full_r;
    oel  = pop_vld & ~(m_rsp_vld & ~rsp_rdy);
    exp_prdy = idle & ~clear_req & pel & (~oel | ~m_rr);
    exp_ordy = idle & ~clear_req & oel & (~pel | m_rr);
    chk("push_rdy", 32'(push_rdy), 32'(exp_prdy));
    chk("pop_rdy", 32'(pop_rdy), 32'(exp_ordy));
    chk("cmd_pass", 32'(cmd_pass), 32'(m_busy == 2));
    chk("clear", 32'(clear), 32'(m_clear_exp));
    chk("rsp_vld", 32'(rsp_vld), 32'(m_rsp_vld));
    if (m_rsp_vld) begin
      chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
      chk("rsp_dat", rsp_dat, m_rsp_dat);
    end
    if (m_busy == 2) begin
      chk("cmd_op", 32'(cmd_op), 32'(m_cmd_op));
      chk("cmd_id", 32'(cmd_id), 32'(m_cmd_id));
    end
    pa = push_vld & exp_prdy;
    oa = pop_vld & exp_ordy;
    take = m_rsp_vld & rsp_rdy;
    clr_next = idle & clear_req;
    fire = cmd_pass; fop = cmd_op; fid = cmd_id; clr = clear;
    @(posedge clk);
    #1;
    if (clr) ctrl_clear();
    else if (fire) begin
      if (fop == PUSH_FRONT || fop == PUSH_BACK) begin
        if (fl.size() > 0) begin
          p = fl.pop_front();
          if (fop == PUSH_BACK) pq[fid].push_back(p);
          else pq[fid].push_front(p);
        end
      end else if (pq[fid].size() > 0) begin
        if (fop == POP_FRONT) p = pq[fid].pop_front();
        else p = pq[fid].pop_back();
        fl.push_back(p);
      end
    end
    if (take) m_rsp_vld = 1'b0;
    if (m_rsp_cnt > 0) begin
      m_rsp_cnt--;
      if (m_rsp_cnt == 0) begin
        m_rsp_vld = 1'b1; m_rsp_err = 1'b0; m_rsp_dat = m_pend_dat;
      end
    end
    m_clear_exp = clr_next;
    if (m_busy > 0) m_busy--;
    if (clr_next) for (int i = 0; i < ID_N; i++) dq[i].delete();
    if (pa) begin
      if (push_back) dq[push_id].push_back(push_dat);
      else dq[push_id].push_front(push_dat);
      m_cmd_op = push_back ? PUSH_BACK : PUSH_FRONT;
      m_cmd_id = push_id;
      m_busy = 2;
      m_rr = ~m_rr;
    end else if (oa) begin
      m_rr = ~m_rr;
      if (dq[pop_id].size() > 0) begin
        m_pend_dat = pop_back ? dq[pop_id].pop_back() : dq[pop_id].pop_front();
        m_rsp_cnt = 2;
        m_busy = 2;
        m_cmd_op = pop_back ? POP_BACK : POP_FRONT;
        m_cmd_id = pop_id;
      end else begin
        m_rsp_vld = 1'b1; m_rsp_err = 1'b1; m_rsp_dat = '0;
      end
    end
    last_pa = pa;
    last_oa = oa;
    drive_ctrl(fire);
  endtask

  task automatic req(input logic is_push, input int id, input logic back, input logic [W-1:0] dat);
    int n = 0;
    if (is_push) begin
      push_vld = 1; push_id = id_t'(id); push_back = back; push_dat = dat;
    end else begin
      pop_vld = 1; pop_id = id_t'(id); pop_back = back;
    end
    do begin
      step();
      n++;
    end while (!(is_push ? last_pa : last_oa) && n < 20);
    push_vld = 0; pop_vld = 0;
    if (!(is_push ? last_pa : last_oa)) fail_now("accept_wait");
  endtask

  task automatic pop_expect(input int id, input logic back, input logic exp_err,
                            input logic [W-1:0] exp_dat, input int exp_lat);
    int n = 0;
    rsp_rdy = 0;
    req(1'b0, id, back, '0);
    if (!exp_err) chk("pop_cmd_pass", 32'(cmd_pass), 1);
    else chk("err_no_cmd_pass", 32'(cmd_pass), 0);
    while (!rsp_vld && n < 10) begin
      step();
      n++;
    end
    chk("pop_latency", 32'(n), 32'(exp_lat));
    chk("pop_lit_err", 32'(rsp_err), 32'(exp_err));
    chk("pop_lit_dat", rsp_dat, exp_dat);
    rsp_rdy = 1;
    step();
    rsp_rdy = 0;
  endtask

  task automatic do_reset();
    inputs_zero();
    rst = 1;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic wait_grant(output logic gp, output logic go);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(last_pa | last_oa) && n < 10);
    gp = last_pa; go = last_oa;
    if (!(last_pa | last_oa)) fail_now("grant_wait");
  endtask

  initial begin
    logic gp, go, prev_clr;
    int n;
    rst = 0;
    inputs_zero();
    model_reset();
    #1 rst = 1;
    do_reset();

    // push back / pop front on queue 1
    req(1'b1, 1, 1'b1, 32'hA5);
    chk("push_cmd_pass", 32'(cmd_pass), 1);
    chk("push_cmd_op", 32'(cmd_op), 32'(PUSH_BACK));
    pop_expect(1, 1'b0, 1'b0, 32'hA5, 2);

    // empty-queue pop
    pop_expect(0, 1'b0, 1'b1, 32'h0, 0);

    // ordering through front pushes
    for (int i = 1; i <= 3; i++) req(1'b1, 2, 1'b0, 32'(i));
    for (int i = 1; i <= 3; i++) pop_expect(2, 1'b1, 1'b0, 32'(i), 2);
    for (int i = 1; i <= 3; i++) req(1'b1, 2, 1'b0, 32'(i));
    for (int i = 3; i >= 1; i--) pop_expect(2, 1'b0, 1'b0, 32'(i), 2);

    // fill every slot, then a pop frees one
    for (int i = 0; i < PTR_N; i++) req(1'b1, 3, 1'b1, 32'(100 + i));
    push_vld = 1; push_id = 3; push_back = 1; push_dat = 32'h77;
    for (int i = 0; i < 4; i++) step();
    chk("full_stall", 32'(push_rdy), 0);
    pop_vld = 1; pop_id = 3; pop_back = 0; rsp_rdy = 1;
    n = 0;
    do begin
      step();
      if (last_oa) pop_vld = 0;
      n++;
    end while (!last_pa && n < 30);
    chk("push_after_pop", 32'(last_pa), 1);
    push_vld = 0; pop_vld = 0;
    for (int i = 0; i < 4; i++) step();
    rsp_rdy = 0;

    // arbitration after reset: push first, then alternate
    do_reset();
    rsp_rdy = 1;
    push_vld = 1; push_id = 0; push_back = 1; push_dat = 32'h1234;
    pop_vld = 1; pop_id = 1; pop_back = 0;
    for (int k = 0; k < 6; k++) begin
      wait_grant(gp, go);
      chk("alt_grant_push", 32'(gp), 32'(k % 2 == 0));
    end
    push_vld = 0; pop_vld = 0;
    step(); step(); step();
    // response stall blocks pops only
    rsp_rdy = 0;
    req(1'b0, 1, 1'b0, '0);
    push_vld = 1; pop_vld = 1;
    for (int k = 0; k < 3; k++) begin
      wait_grant(gp, go);
      chk("stall_grant_push", 32'(gp), 1);
      chk("stall_pop_rdy", 32'(pop_rdy), 0);
    end
    push_vld = 0; pop_vld = 0;
    step(); step(); step();

    // clear with a pending response and pending requests
    clear_req = 1; push_vld = 1; push_id = 0;
    step();
    clear_req = 0; push_vld = 0;
    chk("clear_pulse", 32'(clear), 1);
    chk("clear_keeps_rsp", 32'(rsp_vld), 1);
    step();
    chk("clear_once", 32'(clear), 0);
    rsp_rdy = 1; step(); rsp_rdy = 0;
    pop_expect(0, 1'b0, 1'b1, 32'h0, 0);

    // reset in the ISSUE cycle
    req(1'b1, 2, 1'b1, 32'hBEEF);
    chk("issue_before_rst", 32'(cmd_pass), 1);
    #2 rst = 1;
    #1 check_reset_outputs();
    inputs_zero();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    pop_expect(2, 1'b0, 1'b1, 32'h0, 0);

    // random traffic
    prev_clr = 0;
    for (int c = 0; c < 2000; c++) begin
      push_vld  = ($urandom_range(0, 99) < 45);
      push_id   = id_t'($urandom_range(0, ID_N - 1));
      push_back = 1'($urandom_range(0, 1));
      push_dat  = $urandom;
      pop_vld   = ($urandom_range(0, 99) < 45);
      pop_id    = id_t'($urandom_range(0, ID_N - 1));
      pop_back  = 1'($urandom_range(0, 1));
      rsp_rdy   = ($urandom_range(0, 99) < 70);
      clear_req = ($urandom_range(0, 99) < 2);
      if (prev_clr) begin
        push_vld = 0; pop_vld = 0;
      end
      prev_clr = clear_req;
      step();
    end
    inputs_zero();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/doubly_linked_list_client.md
# doubly_linked_list_client

Request-side front end for the doubly-linked-list controller: accepts per-queue push/pop requests with payload, arbitrates them, and issues single commands on the controller's `cmd_*` interface. Owns the payload store, written at the controller-supplied push pointer and read at its pop pointer. Returns pop data (or an empty-queue error) on a valid/ready response channel. Sits between the client logic and `doubly_linked_list_cntrl`, one instance per list structure.

## Interface
- `W`, 32, payload width in bits.
- `ID_N`, `PTR_N`, `id_t`, `ptr_t`, `op_t`, `empty_t`: taken from `dll_pkg`, not overridable.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `push_vld`  in  1  push request valid.
- `push_id`  in  id_t  target queue.
- `push_back`  in  1  1 = push back, 0 = push front.
- `push_dat`  in  W  payload.
- `push_rdy`  out  1  push accepted when `push_vld & push_rdy`.
- `pop_vld`  in  1  pop request valid.
- `pop_id`  in  id_t  target queue.
- `pop_back`  in  1  1 = pop back, 0 = pop front.
- `pop_rdy`  out  1  pop accepted when `pop_vld & pop_rdy`.
- `rsp_vld`  out  1  pop response valid.
- `rsp_dat`  out  W  popped payload; 0 when `rsp_err`.
- `rsp_err`  out  1  pop targeted an empty queue.
- `rsp_rdy`  in  1  response consumed when `rsp_vld & rsp_rdy`.
- `clear_req`  in  1  level request to flush all queues.
- `cmd_pass`, `cmd_op`, `cmd_id`  out  1/op_t/id_t  registered command to the controller.
- `cmd_push_ptr_r`, `cmd_pop_ptr_w`  in  ptr_t  controller free pointer and current pop pointer.
- `full_r`, `busy_r`  in  1  controller status.
- `nempty_r`  in  empty_t  per-queue non-empty.
- `clear`  out  1  one-cycle flush pulse to the controller.

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset → IDLE.
- IDLE, priority order:
  - `clear_req` → `clear`=1 next cycle, stay IDLE, no request accepted that cycle.
  - Otherwise arbitrate push/pop. Both eligible → round-robin bit picks; bit flips after each grant; reset value favours push.
- `push_rdy` = IDLE & !`clear_req` & !`full_r` & grant.
- `pop_rdy` = IDLE & !`clear_req` & !(`rsp_vld` & !`rsp_rdy`) & grant.
- Accepted push → latch `cmd_op` (PUSH_FRONT/BACK), `cmd_id` and payload; go to ISSUE.
- Accepted pop with `nempty_r[pop_id]`=1 → latch cmd; go to ISSUE.
- Accepted pop with `nempty_r[pop_id]`=0 → no command issued; load rsp with `rsp_err`=1 and `rsp_dat`=0; stay IDLE.
- ISSUE: `cmd_pass`=1.
  - Push: payload RAM write at `cmd_push_ptr_r`.
  - Pop: payload RAM read at `cmd_pop_ptr_w`.
  - Go to WAIT.
- WAIT: `busy_r` is expected to be 1. For a pop, capture RAM dout into the rsp register (`rsp_err`=0). Go to IDLE.
- Rsp register holds until `rsp_vld & rsp_rdy`. A new pop never overwrites an unconsumed response.
- `clear` does not drop a pending response; RAM contents are not cleared.

## Timing
- Reset values: `push_rdy`, `pop_rdy`, `cmd_pass`, `clear`, `rsp_vld`, `rsp_err` = 0; `cmd_op`, `cmd_id`, `rsp_dat` = 0.
- Accept at cycle 0 → `cmd_pass` in cycle 1 → WAIT in cycle 2 → `rsp_vld` from cycle 3.
- Empty-pop error: `rsp_vld` in cycle 1.
- Throughput: one command per 3 cycles.
- `nempty_r` and `full_r` are sampled only in IDLE. At that point both already reflect the previous command.
- Reset asserted mid-operation: FSM → IDLE and any in-flight command is abandoned.

## Structure
- `dll_pkg` gains `client_state_t` (IDLE/ISSUE/WAIT) and `client_rsp_t` {vld, err, dat}.
- Payload store: one `spsram #(.W(W), .N(PTR_N))` instance, enabled only in ISSUE. The `wen` input selects push vs pop.
- Arbiter and FSM are inline; no other sub-modules. Expected size ≈200 lines.

## Test plan
- Push back `id`=1 data 0xA5, then pop front `id`=1 → `cmd_pass` 1 cycle after accept; `rsp_dat`=0xA5, `rsp_err`=0, `rsp_vld` 3 cycles after pop accept.
- Pop `id`=0 on empty queue → no `cmd_pass`; `rsp_vld`=1, `rsp_err`=1, `rsp_dat`=0 next cycle.
- Push front 1,2,3 to `id`=2, pop back ×3 → 1,2,3 in order; pop front ×3 instead → 3,2,1.
- Fill all `PTR_N` entries → `push_rdy`=0 while `full_r`; one pop → a push is then accepted.
- `push_vld` and `pop_vld` held together → grants alternate push/pop starting with push; `rsp_rdy`=0 stalls `pop_rdy` without stalling pushes.
- `clear_req` with requests pending → `clear` pulses once, all `nempty_r`=0; `rst` asserted in ISSUE → all outputs at reset values asynchronously.
